// File: rtl/reg_file_pkg.sv
// Shared widths and the read-port helper for the renaming register file.
// Other blocks import this package to size GPR indices, ROB ids and data.
package reg_file_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int ROB_ADDR_WIDTH = 6;
  localparam int DATA_WIDTH     = 32;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef struct packed {
    logic                  is_ref;
    logic [DATA_WIDTH-1:0] data;
  } read_result_t;

  // Resolves one source operand: disabled or r0 reads as zero, and a pending
  // register returns its producer's ROB id instead of the stale value.
  function automatic read_result_t read_port(
    input logic                      en,
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic                      is_ref,
    input logic [ROB_ADDR_WIDTH-1:0] ref_id,
    input logic [DATA_WIDTH-1:0]     value
  );
    read_result_t res;
    res = '0;
    if (en && (addr != '0)) begin
      if (is_ref) begin
        res.is_ref = 1'b1;
        res.data   = {{(DATA_WIDTH - ROB_ADDR_WIDTH){1'b0}}, ref_id};
      end else begin
        res.data   = value;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural GPR file with rename tags: committed values, pending flags and
// the ROB id of each register's newest in-flight producer.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [REG_ADDR_WIDTH-1:0] write_addr,
  input  logic [ROB_ADDR_WIDTH-1:0] write_ref_id,
  input  logic                      commit_en,
  input  logic                      commit_restore,
  input  logic [REG_ADDR_WIDTH-1:0] commit_addr,
  input  logic [DATA_WIDTH-1:0]     commit_data,
  input  logic                      read_en_1,
  input  logic [REG_ADDR_WIDTH-1:0] read_addr_1,
  output logic                      read_is_ref_1,
  output logic [DATA_WIDTH-1:0]     read_data_1,
  input  logic                      read_en_2,
  input  logic [REG_ADDR_WIDTH-1:0] read_addr_2,
  output logic                      read_is_ref_2,
  output logic [DATA_WIDTH-1:0]     read_data_2
);

  logic [DATA_WIDTH-1:0]     value_q  [NUM_REGS];
  logic [DATA_WIDTH-1:0]     value_d  [NUM_REGS];
  logic [ROB_ADDR_WIDTH-1:0] ref_id_q [NUM_REGS];
  logic [ROB_ADDR_WIDTH-1:0] ref_id_d [NUM_REGS];
  logic [NUM_REGS-1:0]       is_ref_q;
  logic [NUM_REGS-1:0]       is_ref_d;

  logic commit_hit;
  logic write_hit;

  assign commit_hit = commit_en && (commit_addr != '0);
  assign write_hit  = write_en && (write_addr != '0) && !commit_restore;

  // Commit is applied before rename so a same-cycle rename wins the flag
  // while the committed value is still stored.
  always_comb begin
    // NOTE: every always_comb target gets a full default first; a path that
    // leaves one unassigned would infer a latch.
    value_d  = value_q;
    ref_id_d = ref_id_q;
    is_ref_d = is_ref_q;

    if (commit_restore) begin
      is_ref_d = '0;
    end

    if (commit_hit) begin
      value_d[commit_addr]  = commit_data;
      is_ref_d[commit_addr] = 1'b0;
    end

    if (write_hit) begin
      is_ref_d[write_addr] = 1'b1;
      ref_id_d[write_addr] = write_ref_id;
    end
  end

  // Restore leaves ref_id stale on purpose; it is never observed while the
  // matching is_ref bit is clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole array is reset because software-visible state must
      // read as zero after reset; this keeps it in flops rather than a RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i]  <= '0;
        ref_id_q[i] <= '0;
      end
      is_ref_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      value_q  <= value_d;
      ref_id_q <= ref_id_d;
      is_ref_q <= is_ref_d;
    end
  end

  read_result_t rd_1;
  read_result_t rd_2;

  always_comb begin
    rd_1 = read_port(read_en_1, read_addr_1, is_ref_q[read_addr_1],
                     ref_id_q[read_addr_1], value_q[read_addr_1]);
    rd_2 = read_port(read_en_2, read_addr_2, is_ref_q[read_addr_2],
                     ref_id_q[read_addr_2], value_q[read_addr_2]);
  end

  assign read_is_ref_1 = rd_1.is_ref;
  assign read_data_1   = rd_1.data;
  assign read_is_ref_2 = rd_2.is_ref;
  assign read_data_2   = rd_2.data;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: expected read-port results are queued as
// each stimulus cycle is driven and compared once the edge has taken effect.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [5:0]  write_ref_id;
  logic        commit_en;
  logic        commit_restore;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;
  logic        read_en_1;
  logic [4:0]  read_addr_1;
  logic        read_is_ref_1;
  logic [31:0] read_data_1;
  logic        read_en_2;
  logic [4:0]  read_addr_2;
  logic        read_is_ref_2;
  logic [31:0] read_data_2;

  reg_file dut (
    .clk            (clk),
    .rst            (rst),
    .write_en       (write_en),
    .write_addr     (write_addr),
    .write_ref_id   (write_ref_id),
    .commit_en      (commit_en),
    .commit_restore (commit_restore),
    .commit_addr    (commit_addr),
    .commit_data    (commit_data),
    .read_en_1      (read_en_1),
    .read_addr_1    (read_addr_1),
    .read_is_ref_1  (read_is_ref_1),
    .read_data_1    (read_data_1),
    .read_en_2      (read_en_2),
    .read_addr_2    (read_addr_2),
    .read_is_ref_2  (read_is_ref_2),
    .read_data_2    (read_data_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        is_ref_1;
    logic [31:0] data_1;
    logic        is_ref_2;
    logic [31:0] data_2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_passed = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Queue the expected outputs, clock once, drop the one-cycle pulses, then
  // pop and compare against what the DUT now presents.
  task automatic tick(input string tag, input logic r1, input logic [31:0] d1,
                      input logic r2, input logic [31:0] d2);
    exp_t e;
    exp_t got;
    e.tag = tag; e.is_ref_1 = r1; e.data_1 = d1; e.is_ref_2 = r2; e.data_2 = d2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    write_en       = 1'b0;
    commit_en      = 1'b0;
    commit_restore = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check({got.tag, "_is_ref_1"}, {31'd0, read_is_ref_1}, {31'd0, got.is_ref_1});
      check({got.tag, "_data_1"},   read_data_1,            got.data_1);
      check({got.tag, "_is_ref_2"}, {31'd0, read_is_ref_2}, {31'd0, got.is_ref_2});
      check({got.tag, "_data_2"},   read_data_2,            got.data_2);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [5:0] id);
    write_en = 1'b1; write_addr = a; write_ref_id = id;
  endtask

  task automatic do_commit(input logic [4:0] a, input logic [31:0] d);
    commit_en = 1'b1; commit_addr = a; commit_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    write_en = 1'b0; write_addr = '0; write_ref_id = '0;
    commit_en = 1'b0; commit_restore = 1'b0; commit_addr = '0; commit_data = '0;
    read_en_1 = 1'b1; read_addr_1 = 5'd1;
    read_en_2 = 1'b1; read_addr_2 = 5'd2;

    #12;
    check("reset_is_ref_1", {31'd0, read_is_ref_1}, 32'd0);
    check("reset_data_1",   read_data_1,            32'd0);
    check("reset_is_ref_2", {31'd0, read_is_ref_2}, 32'd0);
    check("reset_data_2",   read_data_2,            32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_commit(5'd1, 32'h12345678);
    tick("commit_r1", 1'b0, 32'h12345678, 1'b0, 32'h0);

    do_write(5'd1, 6'h0a);
    tick("rename_r1", 1'b1, 32'h0000000a, 1'b0, 32'h0);

    do_write(5'd2, 6'h0f);
    do_commit(5'd2, 32'habcdef00);
    tick("rename_beats_commit", 1'b1, 32'h0000000a, 1'b1, 32'h0000000f);

    commit_restore = 1'b1;
    tick("restore", 1'b0, 32'h12345678, 1'b0, 32'habcdef00);

    do_write(5'd1, 6'h3f);
    tick("rename_r1_max_id", 1'b1, 32'h0000003f, 1'b0, 32'habcdef00);

    do_commit(5'd1, 32'h00000055);
    tick("commit_clears_tag", 1'b0, 32'h00000055, 1'b0, 32'habcdef00);

    do_write(5'd2, 6'h01);
    do_commit(5'd2, 32'h00000077);
    commit_restore = 1'b1;
    tick("restore_blocks_rename", 1'b0, 32'h00000055, 1'b0, 32'h00000077);

    tick("idle_hold", 1'b0, 32'h00000055, 1'b0, 32'h00000077);

    read_addr_1 = 5'd0; read_addr_2 = 5'd0;
    do_write(5'd0, 6'h05);
    do_commit(5'd0, 32'hdeadbeef);
    tick("r0_ignored", 1'b0, 32'h0, 1'b0, 32'h0);

    read_en_1 = 1'b0; read_addr_1 = 5'd1;
    read_en_2 = 1'b0; read_addr_2 = 5'd2;
    tick("read_disabled", 1'b0, 32'h0, 1'b0, 32'h0);

    read_en_1 = 1'b1; read_en_2 = 1'b1;
    tick("reenable_hold", 1'b0, 32'h00000055, 1'b0, 32'h00000077);

    read_addr_1 = 5'd31;
    do_write(5'd31, 6'h2a);
    do_commit(5'd31, 32'hcafef00d);
    tick("r31_rename_and_commit", 1'b1, 32'h0000002a, 1'b0, 32'h00000077);

    commit_restore = 1'b1;
    tick("r31_restore", 1'b0, 32'hcafef00d, 1'b0, 32'h00000077);

    rst = 1'b1;
    #1;
    check("async_reset_data_1", read_data_1, 32'd0);
    check("async_reset_data_2", read_data_2, 32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
